// File: rtl/i2s_audio_rx.sv
// I2S receiver: recovers 16-bit left/right samples from 32-slot half-frames.
// Define I2S_RX_SYNC_EN to add 2-flop synchronizers on lrck and sdata.
`timescale 1ns/1ps
module i2s_audio_rx #(
  parameter int SCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lrck,
  input  logic        sdata,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        sample_is_right,
  output logic [15:0] left_sample,
  output logic [15:0] right_sample,
  output logic        sync_error,
  output logic        locked
);

  localparam int HALF = SCLK_DIV * SLOT_BITS;
  localparam logic [7:0] LAST     = 8'(HALF - 1);
  localparam logic [7:0] SLOT0_AT = 8'd1;
  localparam logic [7:0] VALID_AT = 8'(SCLK_DIV * 16 + 2);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    DATA,
    PAD
  } state_t;

  logic lrck_s;
  logic sdata_s;

`ifdef I2S_RX_SYNC_EN
  logic [1:0] lrck_sync_q;
  logic [1:0] sdata_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
    end else begin
      lrck_sync_q  <= {lrck_sync_q[0], lrck};
      sdata_sync_q <= {sdata_sync_q[0], sdata};
    end
  end

  assign lrck_s  = lrck_sync_q[1];
  assign sdata_s = sdata_sync_q[1];
`else
  assign lrck_s  = lrck;
  assign sdata_s = sdata;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        lrck_q, lrck_d;
  logic        ch_q, ch_d;
  logic [3:0]  bitn_q, bitn_d;
  logic [15:0] sr_q, sr_d;
  logic [15:0] sample_q, sample_d;
  logic        valid_q, valid_d;
  logic        is_right_q, is_right_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic        err_q, err_d;
  logic        locked_q, locked_d;

  logic        lr_edge;
  logic [7:0]  slot_at;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lrck_d     = lrck_s;
    ch_d       = ch_q;
    bitn_d     = bitn_q;
    sr_d       = sr_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    is_right_d = is_right_q;
    left_d     = left_q;
    right_d    = right_q;
    err_d      = 1'b0;
    locked_d   = locked_q;
    lr_edge    = lrck_s != lrck_q;
    slot_at    = 8'(SCLK_DIV * (int'(bitn_q) + 1) + 1);

    if (state_q != IDLE) cnt_d = cnt_q + 8'd1;

    unique case (state_q)
      IDLE: ;
      DELAY: begin
        if (cnt_q == SLOT0_AT) begin
          state_d = DATA;
          bitn_d  = '0;
        end
      end
      DATA: begin
        if (cnt_q == slot_at) begin
          sr_d   = {sr_q[14:0], sdata_s};
          bitn_d = bitn_q + 4'd1;
          if (bitn_q == 4'd15) state_d = PAD;
        end
      end
      PAD: ;
    endcase

    // Slot 16 is already in sr_q here, so a coincident edge cannot cancel it.
    if (state_q == PAD && cnt_q == VALID_AT) begin
      valid_d    = 1'b1;
      sample_d   = sr_q;
      is_right_d = ch_q;
      if (ch_q) right_d = sr_q;
      else      left_d  = sr_q;
    end

    if (lr_edge) begin
      if (state_q != IDLE) begin
        if (cnt_q == LAST) begin
          locked_d = 1'b1;
        end else begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end
      end
      state_d = DELAY;
      cnt_d   = '0;
      ch_d    = lrck_s;
    end else if (state_q != IDLE && cnt_q == LAST) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      state_d  = IDLE;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lrck_q     <= 1'b0;
      ch_q       <= 1'b0;
      bitn_q     <= '0;
      sr_q       <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      is_right_q <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lrck_q     <= lrck_d;
      ch_q       <= ch_d;
      bitn_q     <= bitn_d;
      sr_q       <= sr_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      is_right_q <= is_right_d;
      left_q     <= left_d;
      right_q    <= right_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign sample          = sample_q;
  assign sample_valid    = valid_q;
  assign sample_is_right = is_right_q;
  assign left_sample     = left_q;
  assign right_sample    = right_q;
  assign sync_error      = err_q;
  assign locked          = locked_q;

endmodule
